// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_pkg
//  Description : Shared types, default sizes and the round-robin pick helper
//                for the shared sequential multiplier arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_share_pkg;

    localparam int C_DEF_WIDTH = 16;
    localparam int C_DEF_NREQ  = 4;
    // Largest requester count the pick helper supports.
    localparam int C_MAX_NREQ  = 8;
    localparam int C_PTR_W     = $clog2(C_MAX_NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot grant for the first set bit of req, searching upward from
    // ptr+1 and wrapping at n. Bits at or above n are never granted.
    function automatic logic [C_MAX_NREQ-1:0] rr_pick(
        input logic [C_MAX_NREQ-1:0] req,
        input int                    ptr,
        input int                    n
    );
        logic [C_MAX_NREQ-1:0] grant;
        logic                  found;
        logic [C_PTR_W-1:0]    sel;
        int                    s;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= C_MAX_NREQ; k++) begin
            if (k <= n) begin
                s = ptr + k;
                if (s >= n) begin
                    s = s - n;
                end
                sel = C_PTR_W'(s);
                if (!found && req[sel]) begin
                    grant[sel] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_core
//  Description : Unsigned shift-add multiplier, one partial-product step per
//                clock. A load starts WIDTH steps; the carry out of each add
//                is shifted into the accumulator so the 2*WIDTH result is
//                exact.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_seq_core #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [C_CNT_W-1:0] r_count;
    logic [WIDTH:0]     w_sum;

    // Upper half plus multiplicand when the current multiplier bit is set;
    // bit WIDTH of w_sum is the carry that becomes the new accumulator MSB.
    always_comb begin
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) begin
            w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
        end
    end

    // Load operands, then add-and-shift right once per clock until count hits 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_a     <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_count <= C_CNT_W'(WIDTH);
        end else if (r_count != '0) begin
            r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
            r_count <= r_count - C_CNT_W'(1);
        end
    end

    // The accumulator holds the final product from the step after done
    // until the next load.
    assign product = r_acc;
    // High during the cycle whose closing edge performs the last step.
    assign done    = (r_count == C_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_arbiter
//  Description : Round-robin sharing of one sequential multiplier between
//                NREQ valid/ready requesters, one operation in flight, with a
//                one-cycle one-hot response pulse to the owner.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int NREQ  = C_DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         resp_valid,
    output logic [IDW-1:0]          resp_id,
    output logic [2*WIDTH-1:0]      resp_product,
    output logic                    busy
);

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_owner;
    logic [NREQ-1:0]    r_resp_valid;

    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_win_idx;
    logic [WIDTH-1:0]   w_win_a;
    logic [WIDTH-1:0]   w_win_b;
    logic               w_load;
    logic               w_core_done;
    logic [2*WIDTH-1:0] w_product;

    // Round-robin winner among currently valid requesters and its operands.
    always_comb begin
        w_grant   = NREQ'(rr_pick(C_MAX_NREQ'(req_valid), 32'(r_ptr), NREQ));
        w_win_idx = '0;
        w_win_a   = '0;
        w_win_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx = IDW'(i);
                w_win_a   = req_a[i*WIDTH +: WIDTH];
                w_win_b   = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grants are only offered while idle; the capture happens on that edge.
    assign w_load    = (r_state == IDLE) && (w_grant != '0);
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    mul_seq_core #(
        .WIDTH   (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .a       (w_win_a),
        .b       (w_win_b),
        .product (w_product),
        .done    (w_core_done)
    );

    // Control FSM: capture in IDLE, wait for the core in BUSY, pulse in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= IDW'(NREQ - 1);
            r_owner      <= '0;
            r_resp_valid <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_owner <= w_win_idx;
                        r_ptr   <= w_win_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_core_done) begin
                        r_resp_valid <= NREQ'(1) << r_owner;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_owner;
    assign resp_product = w_product;
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_arbiter
//  Description : Scoreboard bench for mul_share_arbiter: a transaction-level
//                reference decides who should be granted and when, queues the
//                expected product, and a monitor compares every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef logic [2*WIDTH-1:0] prod_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       resp_valid;
    logic [IDW-1:0]        resp_id;
    prod_t                 resp_product;
    logic                  busy;

    mul_share_arbiter #(
        .WIDTH        (WIDTH),
        .NREQ         (NREQ),
        .IDW          (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one operation at a time; an idle slot arbitrates
    // round-robin; the response is due WIDTH+1 cycles after capture and the
    // next idle slot comes one cycle after that.
    // ------------------------------------------------------------------
    typedef struct {
        int    id;
        prod_t prod;
        int    due;
    } exp_t;

    exp_t  q[$];
    int    m_ptr     = NREQ - 1;
    int    m_free    = 0;
    int    last_id   = 0;
    prod_t last_prod = '0;

    always @(negedge clk) begin
        exp_t            e;
        logic [NREQ-1:0] g;
        int              widx;
        bit              found;
        if (!rst_n) begin
            q.delete();
            m_ptr     = NREQ - 1;
            m_free    = cyc + 1;
            last_id   = 0;
            last_prod = '0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("resp_valid", resp_valid, 64'(1) << e.id);
                chk("resp_id", resp_id, e.id);
                chk("resp_product", resp_product, e.prod);
                last_id   = e.id;
                last_prod = e.prod;
            end else begin
                chk("no_spurious_resp", resp_valid, 0);
            end
            chk("busy", busy, cyc < m_free);
            if (cyc < m_free) begin
                chk("ready_while_busy", req_ready, 0);
            end else begin
                g     = '0;
                widx  = 0;
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                        widx    = (m_ptr + k) % NREQ;
                        found   = 1;
                        g[widx] = 1'b1;
                    end
                end
                chk("grant", req_ready, g);
                chk("hold_id", resp_id, last_id);
                chk("hold_product", resp_product, last_prod);
                if (found) begin
                    q.push_back('{widx,
                                  prod_t'(req_a[widx*WIDTH +: WIDTH]) * prod_t'(req_b[widx*WIDTH +: WIDTH]),
                                  cyc + 1 + WIDTH});
                    m_ptr  = widx;
                    m_free = cyc + WIDTH + 2;
                end
            end
        end
    end

    // Requesters must hold valid until their grant.
    logic [NREQ-1:0] pv_valid = '0;
    logic [NREQ-1:0] pv_ready = '0;
    logic            pv_rst   = 1'b0;
    always @(negedge clk) begin
        if (rst_n && pv_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                assert (!(pv_valid[i] && !pv_ready[i] && !req_valid[i]))
                    else $error("protocol: requester %0d dropped valid before ready", i);
            end
        end
        pv_valid = req_valid;
        pv_ready = req_ready;
        pv_rst   = rst_n;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int glog[$];

    task automatic step(output logic [NREQ-1:0] g);
        @(negedge clk);
        g = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) glog.push_back(i);
        end
        req_valid = req_valid & ~g;
    endtask

    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i]            = 1'b1;
    endtask

    task automatic drain(input int budget);
        logic [NREQ-1:0] g;
        int              n;
        n = 0;
        do begin
            step(g);
            n++;
        end while ((req_valid != '0 || busy || q.size() != 0) && n < budget);
        if (req_valid != '0 || busy || q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d ops still outstanding after %0d cycles", q.size(), budget);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_resp_product"}, resp_product, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        logic [NREQ-1:0] g;
        int              n1, n3, n;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Single requests, including carry-heavy operands; last served is 3.
        issue(0, 16'd3, 16'd5);          drain(100);
        issue(1, 16'h8000, 16'd2);       drain(100);
        issue(3, 16'hFFFF, 16'hFFFF);    drain(100);

        // All four at once: pointer at 3 gives order 0,1,2,3.
        glog.delete();
        issue(0, 16'd2, 16'd3);
        issue(1, 16'd4, 16'd5);
        issue(2, 16'd6, 16'd7);
        issue(3, 16'd8, 16'd9);
        drain(200);
        chk("all4_count", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) chk("all4_order", glog[k], k);

        // Fairness: 1 and 3 each re-request after their first grant.
        glog.delete();
        n1 = 0; n3 = 0; n = 0;
        issue(3, 16'd11, 16'd13);
        issue(1, 16'd17, 16'd19);
        while (glog.size() < 4 && n < 300) begin
            step(g);
            n++;
            if (g[1]) begin n1++; if (n1 < 2) issue(1, rnd_op(), rnd_op()); end
            if (g[3]) begin n3++; if (n3 < 2) issue(3, rnd_op(), rnd_op()); end
        end
        drain(100);
        chk("fair_count", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) chk("fair_order", glog[k], (k % 2 == 0) ? 1 : 3);

        // Reset in the middle of an operation.
        issue(0, 16'd7, 16'd9);
        n = 0;
        do begin step(g); n++; end while (!g[0] && n < 100);
        chk("midreset_granted", g[0], 1);
        repeat (7) step(g);
        rst_n = 1'b0;
        step(g);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        repeat (20) step(g);
        glog.delete();
        issue(3, 16'd2, 16'd3);
        issue(0, 16'd7, 16'd9);
        drain(100);
        chk("midreset_tie_winner", (glog.size() > 0) ? glog[0] : -1, 0);

        // Zero operands.
        issue(2, 16'd0, 16'h1234);       drain(100);
        issue(2, 16'h1234, 16'd0);       drain(100);

        // Random traffic.
        repeat (800) begin
            step(g);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) issue(i, rnd_op(), rnd_op());
            end
        end
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
